// File: rtl/debug_slave_cmd_sync.sv
// System-clock side of the CPU debug slave: synchronises the JTAG update strobes,
// captures IR/DR into a small command FIFO and issues commands with valid/ready.
module debug_slave_cmd_sync #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NCH   = 2 ** IR_W,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int LVL_W = PTR_W + 1,
    localparam int ENT_W = IR_W + DR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IR_W-1:0]  ir_in,
    input  logic [DR_W-1:0]  sr,
    input  logic             vs_uir,
    input  logic             vs_e1dr,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [DR_W-1:0]  jdo,
    output logic [IR_W-1:0]  cmd_ir,
    output logic [NCH-1:0]   take_action,
    output logic [NCH-1:0]   take_no_action,
    output logic [IR_W-1:0]  ir_latched,
    output logic [LVL_W-1:0] fifo_level,
    output logic [7:0]       overflow_cnt
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] uir_sync, e1dr_sync;
    logic                   uir_d, e1dr_d;
    logic                   uir_rise, e1dr_rise;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, view_ptr;
    logic [ENT_W-1:0] head;
    logic             full, pop, push, drop;

    // Synchroniser chains: all flops reset high so a strobe already high at
    // reset release must first be seen low before it can raise an event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uir_sync  <= '1;
            e1dr_sync <= '1;
            uir_d     <= 1'b1;
            e1dr_d    <= 1'b1;
        end else begin
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            e1dr_sync <= {e1dr_sync[SYNC_STAGES-2:0], vs_e1dr};
            uir_d     <= uir_sync[SYNC_STAGES-1];
            e1dr_d    <= e1dr_sync[SYNC_STAGES-1];
        end
    end

    assign uir_rise  = uir_sync[SYNC_STAGES-1] & ~uir_d;
    assign e1dr_rise = e1dr_sync[SYNC_STAGES-1] & ~e1dr_d;

    assign cmd_valid = (fifo_level != '0);
    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop       = cmd_valid & cmd_ready & reset_n;
    assign push      = e1dr_rise & (~full | pop);
    assign drop      = e1dr_rise & full & ~pop;

    // When empty, show the slot just behind rd_ptr so the last popped command stays visible.
    assign view_ptr = cmd_valid ? rd_ptr : rd_ptr - PTR_W'(1);
    assign head     = mem[view_ptr];
    assign jdo      = head[DR_W-1:0];
    assign cmd_ir   = head[ENT_W-1:DR_W];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            ir_latched   <= '0;
            overflow_cnt <= '0;
        end else begin
            if (uir_rise) ir_latched <= ir_in;
            // A same-edge uir event still pushes the previous ir_latched.
            if (push) begin
                mem[wr_ptr] <= {ir_latched, sr};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (drop) overflow_cnt <= sat_inc(overflow_cnt);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (pop) begin
            if (jdo[DR_W-1]) take_action[cmd_ir]    = 1'b1;
            else             take_no_action[cmd_ir] = 1'b1;
        end
    end

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Directed bench for debug_slave_cmd_sync with an expected-command scoreboard.
module tb_debug_slave_cmd_sync;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir, vs_e1dr, cmd_ready;
    logic        cmd_valid;
    logic [37:0] jdo;
    logic [1:0]  cmd_ir;
    logic [3:0]  take_action, take_no_action;
    logic [1:0]  ir_latched;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    int errors = 0;
    int checks = 0;
    logic [39:0] exp_q[$];
    logic [1:0]  ir_model;

    debug_slave_cmd_sync dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_uir(vs_uir), .vs_e1dr(vs_e1dr), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .jdo(jdo), .cmd_ir(cmd_ir),
        .take_action(take_action), .take_no_action(take_no_action),
        .ir_latched(ir_latched), .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic uir(input logic [1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        tick(1);
        vs_uir = 1'b0;
        tick(2);
        ir_model = v;
    endtask

    task automatic e1dr(input logic [37:0] d, input bit exp_push);
        sr = d;
        if (exp_push) exp_q.push_back({ir_model, d});
        vs_e1dr = 1'b1;
        tick(1);
        vs_e1dr = 1'b0;
        tick(2);
    endtask

    // Scoreboard: every accepted head is compared with the oldest expected command.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'd1, 64'd0);
            end else begin
                logic [39:0] e;
                logic [3:0]  oh;
                e  = exp_q.pop_front();
                oh = 4'b0001 << e[39:38];
                check("pop_jdo", 64'(jdo), 64'(e[37:0]));
                check("pop_cmd_ir", 64'(cmd_ir), 64'(e[39:38]));
                check("pop_take_action", 64'(take_action), e[37] ? 64'(oh) : 64'd0);
                check("pop_take_no_action", 64'(take_no_action), e[37] ? 64'd0 : 64'(oh));
            end
        end
    end

    initial begin
        reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_e1dr = 1'b0;
        cmd_ready = 1'b0; ir_model = '0;
        tick(1);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        check("rst_ir_latched", 64'(ir_latched), 64'd0);
        check("rst_ovf", 64'(overflow_cnt), 64'd0);
        check("rst_take", 64'({take_action, take_no_action}), 64'd0);
        tick(1);
        reset_n = 1'b1;
        tick(2);

        // Basic action command with latency checks
        cmd_ready = 1'b1;
        ir_in = 2'b10; vs_uir = 1'b1;
        tick(1);
        check("uir_lat_k", 64'(ir_latched), 64'd0);
        vs_uir = 1'b0;
        tick(1);
        check("uir_lat_k1", 64'(ir_latched), 64'd0);
        tick(1);
        check("uir_lat_k2", 64'(ir_latched), 64'd2);
        ir_model = 2'd2;
        sr = 38'h20_0000_1234;
        exp_q.push_back({ir_model, sr});
        vs_e1dr = 1'b1;
        tick(1);
        check("e1dr_valid_k", 64'(cmd_valid), 64'd0);
        vs_e1dr = 1'b0;
        tick(1);
        check("e1dr_valid_k1", 64'(cmd_valid), 64'd0);
        tick(1);
        check("e1dr_valid_k2", 64'(cmd_valid), 64'd1);
        check("e1dr_jdo_k2", 64'(jdo), 64'h20_0000_1234);
        tick(1);
        check("basic_empty_valid", 64'(cmd_valid), 64'd0);
        check("basic_empty_level", 64'(fifo_level), 64'd0);
        check("basic_hold_jdo", 64'(jdo), 64'h20_0000_1234);
        check("basic_hold_ir", 64'(cmd_ir), 64'd2);

        // Back-pressure and overflow
        cmd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) e1dr(38'(i), i <= 4);
        check("bp_level", 64'(fifo_level), 64'd4);
        check("bp_ovf", 64'(overflow_cnt), 64'd2);
        check("bp_head", 64'(jdo), 64'd1);
        cmd_ready = 1'b1;
        tick(4);
        check("bp_drained", 64'(fifo_level), 64'd0);
        cmd_ready = 1'b0;

        // Push and pop in the same cycle while full
        for (int i = 11; i <= 14; i++) e1dr(38'(i), 1'b1);
        check("pp_full", 64'(fifo_level), 64'd4);
        sr = 38'd15;
        exp_q.push_back({ir_model, sr});
        vs_e1dr = 1'b1;
        tick(1);
        vs_e1dr = 1'b0;
        tick(1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("pp_level", 64'(fifo_level), 64'd4);
        check("pp_ovf", 64'(overflow_cnt), 64'd2);
        check("pp_head", 64'(jdo), 64'd12);
        cmd_ready = 1'b1;
        tick(4);
        check("pp_drained", 64'(fifo_level), 64'd0);
        cmd_ready = 1'b0;

        // Simultaneous uir and e1dr events
        uir(2'd1);
        ir_in = 2'd3;
        sr = 38'h20_0000_0ABC;
        exp_q.push_back({2'd1, sr});
        vs_uir = 1'b1; vs_e1dr = 1'b1;
        tick(1);
        vs_uir = 1'b0; vs_e1dr = 1'b0;
        tick(2);
        ir_model = 2'd3;
        check("sim_ir_latched", 64'(ir_latched), 64'd3);
        check("sim_cmd_ir", 64'(cmd_ir), 64'd1);
        check("sim_level", 64'(fifo_level), 64'd1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("sim_drained", 64'(fifo_level), 64'd0);

        // Strobe held high across reset release
        reset_n = 1'b0;
        vs_e1dr = 1'b1;
        tick(2);
        exp_q.delete();
        ir_model = '0;
        reset_n = 1'b1;
        tick(4);
        check("rsthi_level", 64'(fifo_level), 64'd0);
        check("rsthi_valid", 64'(cmd_valid), 64'd0);
        vs_e1dr = 1'b0;
        tick(2);
        e1dr(38'h55, 1'b1);
        check("rsthi_one_push", 64'(fifo_level), 64'd1);

        // Reset with three entries queued
        e1dr(38'h66, 1'b1);
        e1dr(38'h77, 1'b1);
        check("mid_level3", 64'(fifo_level), 64'd3);
        reset_n = 1'b0;
        cmd_ready = 1'b1;
        #1;
        check("mid_take_in_reset", 64'({take_action, take_no_action}), 64'd0);
        tick(1);
        check("mid_valid", 64'(cmd_valid), 64'd0);
        check("mid_level", 64'(fifo_level), 64'd0);
        check("mid_ovf", 64'(overflow_cnt), 64'd0);
        check("mid_take_after", 64'({take_action, take_no_action}), 64'd0);
        cmd_ready = 1'b0;
        exp_q.delete();
        reset_n = 1'b1;
        tick(2);

        // Overflow counter saturation
        for (int i = 0; i < 4; i++) e1dr(38'(100 + i), 1'b1);
        check("sat_full", 64'(fifo_level), 64'd4);
        for (int i = 0; i < 254; i++) e1dr(38'(200 + i), 1'b0);
        check("sat_254", 64'(overflow_cnt), 64'd254);
        e1dr(38'h1FF, 1'b0);
        check("sat_255", 64'(overflow_cnt), 64'd255);
        for (int i = 0; i < 45; i++) e1dr(38'(500 + i), 1'b0);
        check("sat_300", 64'(overflow_cnt), 64'd255);
        check("sat_level", 64'(fifo_level), 64'd4);
        cmd_ready = 1'b1;
        tick(4);
        cmd_ready = 1'b0;
        check("sat_drained", 64'(fifo_level), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
